// File: rtl/ddr_word_assembler.sv
// Pairs falling/rising-edge DDR samples into 2*WIDTH-bit words and queues them in a
// show-ahead FIFO with occupancy count and a sticky overflow flag.
module ddr_word_assembler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           ddr_in,
  output logic [2*WIDTH-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0]   neg_q;
  logic               neg_en;
  logic [2*WIDTH-1:0] stage_q;
  logic               stage_v;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q  <= '0;
      neg_en <= 1'b0;
    end else begin
      neg_q  <= ddr_in;
      neg_en <= enable;
    end
  end

  // A word forms only when both halves were enabled; a lone half is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      stage_v <= 1'b0;
    end else if (enable && neg_en) begin
      stage_q <= {ddr_in, neg_q};
      stage_v <= 1'b1;
    end else begin
      stage_v <= 1'b0;
    end
  end

  assign out_valid = (level != '0);
  assign full      = (level == FULL_LEVEL);
  assign pop       = out_valid && out_ready;
  assign push_ok   = stage_v && (!full || pop);
  assign drop      = stage_v && full && !pop;

  // NOTE: storage is left unreset; out_data is masked to zero whenever the FIFO is
  // empty, so stale or uninitialised entries are never observable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= stage_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop on the same edge as a clear wins, so no lost word goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/ddr_word_assembler.md
DDR_WORD_ASSEMBLER -- requirements
Module: ddr_word_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of one DDR sample.
REQ-002 SHALL have parameter DEPTH, default 4, giving the output FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; DDR samples are taken on both edges.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: capture enable, sampled on each clk edge together with the data.
REQ-006 SHALL have port ddr_in, input, WIDTH bits: DDR data, valid around both clk edges.
REQ-007 SHALL have port out_data, output, 2*WIDTH bits: head-of-FIFO word.
REQ-008 SHALL have port out_valid, output, 1 bit: FIFO non-empty; out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the word; a pop occurs when out_valid and out_ready are both 1 at a posedge.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag meaning a word was dropped.
REQ-012 SHALL have port clear_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-013 SHALL capture ddr_in into neg_q and enable into neg_en on every falling clk edge, using a dedicated negedge process.
REQ-014 SHALL perform all other sequential logic on the rising clk edge only; no process SHALL be sensitive to both edges.
REQ-015 At a rising edge where enable=1 and neg_en=1, SHALL load stage_q with {ddr_in, neg_q} (rising-edge sample in the upper half, preceding falling-edge sample in the lower half) and SHALL set stage_v=1.
REQ-016 At a rising edge where enable=0 or neg_en=0, SHALL set stage_v=0; a half pair SHALL be discarded, never carried forward.
REQ-017 When stage_v=1, SHALL attempt a FIFO push of stage_q at the next rising edge; total latency SHALL be 2 rising edges from the pair-completing edge to out_valid=1, with the FIFO previously empty.
REQ-018 The FIFO SHALL be show-ahead: out_data SHALL equal the oldest stored word whenever out_valid=1.
REQ-019 SHALL accept a push if level<DEPTH, or if level==DEPTH and a pop occurs on the same edge.
REQ-020 A push attempted when level==DEPTH with no pop SHALL drop the word, leave the FIFO contents unchanged, and set overflow=1.
REQ-021 A pop when out_valid=0 SHALL be ignored, with no pointer or level change.
REQ-022 A simultaneous push and pop SHALL leave level unchanged; otherwise level SHALL change by +1 or -1 exactly.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 clear_ovf=1 SHALL clear overflow at the next posedge, unless an overflow drop occurs on the same edge; in that case overflow SHALL remain 1.
REQ-025 out_valid SHALL equal (level!=0).

Reset
REQ-026 rst_n=0 SHALL asynchronously clear neg_q, neg_en, stage_q, stage_v, the FIFO pointers, level and overflow; out_valid SHALL be 0 and out_data SHALL be 0 while in reset.
REQ-027 Assertion of rst_n mid-stream SHALL discard all staged and stored words; after release, the first word SHALL require a complete falling-then-rising pair with enable=1 on both edges.
REQ-028 FIFO storage contents SHALL NOT require reset; out_data SHALL be 0 whenever level==0.

Verification
REQ-029 SHALL cover basic pairing (WIDTH=8): ddr_in=0x11 at a falling edge, then 0x22 at the next rising edge, enable=1, out_ready=1 -> out_data=0x2211 and out_valid=1 exactly 2 rising edges later, for one cycle only.
REQ-030 SHALL cover partial pair: enable=0 at the falling edge and 1 at the rising edge -> no word produced and level stays 0.
REQ-031 SHALL cover overflow (DEPTH=4): 5 consecutive pairs with out_ready=0 -> level=4 and overflow=1; the dropped word is the 5th; popping 4 times returns words 1..4 in order.
REQ-032 SHALL cover full with simultaneous push and pop: level=4, out_ready=1 while a new pair arrives -> level stays 4, overflow stays 0, and ordering is preserved.
REQ-033 SHALL cover clear race: clear_ovf=1 on the same edge as a drop -> overflow=1; clear_ovf=1 on the next edge with no drop -> overflow=0.
REQ-034 SHALL cover reset mid-stream: rst_n pulsed low with level=3 -> immediately out_valid=0 and level=0; after release, an incomplete pair yields no word.
